// File: rtl/scs_check_if.sv
// Bus bundle between the checksum checker and its RAM/controller environment.
// master = the checker side, slave = the environment that owns the RAM and start request.
interface scs_check_if #(
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 11
);
    logic                     mem_ready;
    logic [RAM_ADDR_BITS-1:0] address;
    logic [RAM_WIDTH-1:0]     mem_output;
    logic [15:0]              payload_len;
    logic                     work_complete;
    logic                     check_ok;
    logic                     check_fail;
    logic                     len_error;
    logic [15:0]              computed_scs;
    logic [15:0]              received_scs;

    modport master (
        input  mem_ready, mem_output, payload_len,
        output address, work_complete, check_ok, check_fail, len_error,
               computed_scs, received_scs
    );

    modport slave (
        output mem_ready, mem_output, payload_len,
        input  address, work_complete, check_ok, check_fail, len_error,
               computed_scs, received_scs
    );
endinterface

// File: rtl/scs_check.sv
// Receive-side checksum verifier: reads L payload bytes plus the trailing
// {hi, lo} shifted checksum from RAM and reports match, mismatch or length error.
module scs_check #(
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 11
) (
    input  logic        clock,
    input  logic        reset,
    scs_check_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Largest L that still leaves room for the two checksum bytes.
    localparam logic [16:0] LEN_MAX = 17'((32'd1 << RAM_ADDR_BITS) - 32'd2);

    state_e                   state_q;
    logic [RAM_ADDR_BITS-1:0] address_q;
    logic [15:0]              acc_q;
    logic [RAM_WIDTH-1:0]     hi_q;
    logic                     len_err_path_q;
    logic                     work_complete_q;
    logic                     check_ok_q;
    logic                     check_fail_q;
    logic                     len_error_q;
    logic [15:0]              computed_scs_q;
    logic [15:0]              received_scs_q;

    logic [RAM_WIDTH-1:0]     rd_byte_s;
    logic [15:0]              addr_ext_s;
    logic [15:0]              shifted_s;
    logic [15:0]              sum_d;
    logic [15:0]              received_d;
    logic                     len_bad_s;

    // Datapath: weighted byte, running sum, assembled received checksum, length limit.
    always_comb begin
        rd_byte_s  = bus.mem_output;
        addr_ext_s = 16'(address_q);
        shifted_s  = 16'(rd_byte_s) << address_q[1:0];
        sum_d      = acc_q + shifted_s;
        received_d = {hi_q, rd_byte_s};
        len_bad_s  = ({1'b0, bus.payload_len} > LEN_MAX);
    end

    // Control FSM with registered outputs; work_complete defaults low so it is a single-cycle pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            address_q       <= {RAM_ADDR_BITS{1'b0}};
            acc_q           <= 16'd0;
            hi_q            <= {RAM_WIDTH{1'b0}};
            len_err_path_q  <= 1'b0;
            work_complete_q <= 1'b0;
            check_ok_q      <= 1'b0;
            check_fail_q    <= 1'b0;
            len_error_q     <= 1'b0;
            computed_scs_q  <= 16'd0;
            received_scs_q  <= 16'd0;
        end else begin
            work_complete_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    address_q <= {RAM_ADDR_BITS{1'b0}};
                    acc_q     <= 16'd0;
                    if (bus.mem_ready) begin
                        check_ok_q     <= 1'b0;
                        check_fail_q   <= 1'b0;
                        len_error_q    <= 1'b0;
                        computed_scs_q <= 16'd0;
                        received_scs_q <= 16'd0;
                        len_err_path_q <= len_bad_s;
                        state_q        <= len_bad_s ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    state_q <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    if (addr_ext_s < bus.payload_len) begin
                        acc_q     <= sum_d;
                        address_q <= address_q + RAM_ADDR_BITS'(1);
                        state_q   <= ST_WAIT;
                    end else if (addr_ext_s == bus.payload_len) begin
                        hi_q      <= rd_byte_s;
                        address_q <= address_q + RAM_ADDR_BITS'(1);
                        state_q   <= ST_WAIT;
                    end else begin
                        // Address L+1: low byte is on the bus; finalise the result.
                        computed_scs_q  <= acc_q;
                        received_scs_q  <= received_d;
                        check_ok_q      <= (acc_q == received_d);
                        check_fail_q    <= (acc_q != received_d);
                        work_complete_q <= 1'b1;
                        state_q         <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (len_err_path_q) begin
                        work_complete_q <= 1'b1;
                        len_error_q     <= 1'b1;
                        check_fail_q    <= 1'b1;
                        check_ok_q      <= 1'b0;
                        computed_scs_q  <= 16'd0;
                        received_scs_q  <= 16'd0;
                    end
                    address_q <= {RAM_ADDR_BITS{1'b0}};
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    address_q <= {RAM_ADDR_BITS{1'b0}};
                end
            endcase
        end
    end

    assign bus.address       = address_q;
    assign bus.work_complete = work_complete_q;
    assign bus.check_ok      = check_ok_q;
    assign bus.check_fail    = check_fail_q;
    assign bus.len_error     = len_error_q;
    assign bus.computed_scs  = computed_scs_q;
    assign bus.received_scs  = received_scs_q;

endmodule

// File: tb/tb_scs_check.sv
// Randomised self-checking bench for scs_check against a behavioural RAM and
// checksum model (sum of byte << (i mod 4), truncated to 16 bits).
module tb_scs_check;

    localparam int AW    = 11;
    localparam int DEPTH = 1 << AW;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] ram [0:DEPTH-1];

    scs_check_if #(.RAM_WIDTH(8), .RAM_ADDR_BITS(AW)) bus ();

    scs_check #(.RAM_WIDTH(8), .RAM_ADDR_BITS(AW)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Synchronous-read RAM: data valid one cycle after the address is presented.
    always @(posedge clock) bus.mem_output <= ram[bus.address];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_scs(input int len);
        int sum;
        sum = 0;
        for (int i = 0; i < len; i++) sum += int'(ram[i]) * (1 << (i % 4));
        return 16'(sum);
    endfunction

    // Random payload; checksum bytes either correct or deliberately corrupted.
    task automatic fill_payload(input int len, input bit corrupt);
        logic [15:0] s;
        for (int i = 0; i < len; i++) ram[i] = 8'($urandom_range(0, 255));
        s = model_scs(len);
        if (corrupt) s = s ^ 16'($urandom_range(1, 65535));
        ram[len]     = s[15:8];
        ram[len + 1] = s[7:0];
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_outs"},
                 {bus.work_complete, bus.check_ok, bus.check_fail, bus.len_error,
                  bus.computed_scs | bus.received_scs, 16'(bus.address)},
                 32'd0);
    endtask

    // Called at a negedge; starts a check, measures latency and compares against the model.
    task automatic run_check(input string tag, input int len, input bit keep_ready);
        bit          exp_lerr;
        logic [15:0] exp_comp, exp_recv;
        int          exp_lat, cyc;
        bit          seen, early_flag, addr_moved;
        exp_lerr = (len > DEPTH - 2);
        exp_comp = exp_lerr ? 16'd0 : model_scs(len);
        exp_recv = exp_lerr ? 16'd0 : {ram[len], ram[len + 1]};
        exp_lat  = exp_lerr ? 1 : 2 * (len + 2);
        bus.payload_len = 16'(len);
        bus.mem_ready   = 1'b1;
        @(posedge clock);
        #1;
        if (!keep_ready) bus.mem_ready = 1'b0;
        cyc = 0; seen = 1'b0; early_flag = 1'b0; addr_moved = 1'b0;
        while (!seen && cyc < 6000) begin
            @(negedge clock);
            if (bus.work_complete) seen = 1'b1;
            else begin
                if (bus.check_ok || bus.check_fail) early_flag = 1'b1;
                cyc++;
            end
            if (bus.address != '0) addr_moved = 1'b1;
        end
        check_eq({tag, "_seen"}, 32'(seen), 32'd1);
        check_eq({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        check_eq({tag, "_early"}, 32'(early_flag), 32'd0);
        if (exp_lerr) check_eq({tag, "_addr0"}, 32'(addr_moved), 32'd0);
        check_eq({tag, "_lerr"}, 32'(bus.len_error), 32'(exp_lerr));
        check_eq({tag, "_ok"}, 32'(bus.check_ok), 32'(!exp_lerr && exp_comp == exp_recv));
        check_eq({tag, "_fail"}, 32'(bus.check_fail), 32'(exp_lerr || exp_comp != exp_recv));
        check_eq({tag, "_comp"}, 32'(bus.computed_scs), 32'(exp_comp));
        check_eq({tag, "_recv"}, 32'(bus.received_scs), 32'(exp_recv));
        @(negedge clock);
        check_eq({tag, "_pulse1"}, 32'(bus.work_complete), 32'd0);
    endtask

    initial begin
        int n;
        bus.mem_ready   = 1'b0;
        bus.payload_len = 16'd0;
        for (int i = 0; i < DEPTH; i++) ram[i] = 8'h00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_idle_outputs("reset");

        // Directed: small match, then mismatch
        ram[0] = 8'h01; ram[1] = 8'h02; ram[2] = 8'h03; ram[3] = 8'h04; ram[4] = 8'h05;
        ram[5] = 8'h00; ram[6] = 8'h36;
        run_check("l5_ok", 5, 1'b0);
        check_eq("l5_const", 32'(bus.computed_scs), 32'h0036);
        ram[6] = 8'h37;
        run_check("l5_bad", 5, 1'b0);

        // Accumulator wrap-around
        for (int i = 0; i < 600; i++) ram[i] = 8'hFF;
        ram[600] = 8'hC1; ram[601] = 8'h36;
        run_check("wrap", 600, 1'b0);
        check_eq("wrap_const", 32'(bus.computed_scs), 32'hC136);

        // Zero length
        ram[0] = 8'h00; ram[1] = 8'h00;
        run_check("l0", 0, 1'b0);

        // Length limit boundary
        run_check("l2047", 2047, 1'b0);
        fill_payload(2046, 1'b0);
        run_check("l2046", 2046, 1'b0);

        // Abort with reset while address = 3
        ram[0] = 8'h01; ram[1] = 8'h02; ram[2] = 8'h03; ram[3] = 8'h04; ram[4] = 8'h05;
        ram[5] = 8'h00; ram[6] = 8'h36;
        bus.payload_len = 16'd5;
        bus.mem_ready   = 1'b1;
        @(posedge clock);
        #1 bus.mem_ready = 1'b0;
        n = 0;
        while (bus.address != 11'd3 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check_eq("abort_reach", 32'(bus.address), 32'd3);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_idle_outputs("abort");
        @(negedge clock);
        reset = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (bus.work_complete) check_eq("abort_nopulse", 32'(bus.work_complete), 32'd0);
        end
        run_check("restart", 5, 1'b0);

        // Randomised lengths and corruption
        for (int k = 0; k < 8; k++) begin
            n = $urandom_range(0, 40);
            fill_payload(n, 1'(($urandom_range(0, 1))));
            run_check($sformatf("rnd%0d", k), n, 1'b0);
        end

        // Back-to-back with mem_ready held high
        for (int k = 0; k < 3; k++) begin
            n = $urandom_range(0, 12);
            fill_payload(n, 1'(k == 1));
            run_check($sformatf("b2b%0d", k), n, 1'b1);
        end
        bus.mem_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
